// File: rtl/qlearn_episode_ctrl_if.sv
// qlearn_episode_ctrl_if: (state, action) issue channel and next-state return channel
// Ports: sa_valid/sa_ready handshake carrying sa_state, sa_action, sa_explore;
//        ns_valid/ns_state next-state result from the pipeline.
interface qlearn_episode_ctrl_if #(
  parameter int STATE_WIDTH = 6,
  parameter int ACTION_WIDTH = 2
);
  logic sa_valid;
  logic sa_ready;
  logic [STATE_WIDTH-1:0] sa_state;
  logic [ACTION_WIDTH-1:0] sa_action;
  logic sa_explore;
  logic ns_valid;
  logic [STATE_WIDTH-1:0] ns_state;
  modport master (output sa_valid, sa_state, sa_action, sa_explore, input sa_ready, ns_valid, ns_state);
  modport slave (input sa_valid, sa_state, sa_action, sa_explore, output sa_ready, ns_valid, ns_state);
endinterface

// File: rtl/qlearn_episode_ctrl.sv
// qlearn_episode_ctrl: walks one Q-learning episode, choosing epsilon-greedy actions per step
// Ports: clk, rst_n (async active-low); start/start_state/end_state/epsilon episode setup;
//        greedy_addr/greedy_action greedy table (1-cycle read); pipe issue/return channel;
//        busy, done, done_timeout, step_count, episode_count status.
module qlearn_episode_ctrl #(
  parameter int STATE_WIDTH = 6,
  parameter int ACTION_WIDTH = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int MAX_STEPS = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [STATE_WIDTH-1:0] start_state,
  input  logic [STATE_WIDTH-1:0] end_state,
  input  logic [7:0] epsilon,
  output logic [STATE_WIDTH-1:0] greedy_addr,
  input  logic [ACTION_WIDTH-1:0] greedy_action,
  qlearn_episode_ctrl_if.master pipe,
  output logic busy,
  output logic done,
  output logic done_timeout,
  output logic [7:0] step_count,
  output logic [15:0] episode_count
);
  typedef enum logic [2:0] {IDLE, FETCH, SELECT, ISSUE, WAIT_NS, DONE} state_t;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  state_t state, next;
  logic [STATE_WIDTH-1:0] cur_state, end_q;
  logic [15:0] lfsr;
  logic tmo, explore;
  assign explore = lfsr[7:0] < epsilon;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign greedy_addr = cur_state;
  assign pipe.sa_valid = state == ISSUE;
  always_comb begin
    next = state;
    tmo = 1'b0;
    case (state)
      IDLE: next = start ? ((start_state == end_state) ? DONE : FETCH) : IDLE;
      FETCH: next = SELECT;
      SELECT: next = ISSUE;
      ISSUE: next = pipe.sa_ready ? WAIT_NS : ISSUE;
      WAIT_NS: begin
        // reaching the end state takes priority over the step limit
        next = !pipe.ns_valid ? WAIT_NS :
               (pipe.ns_state == end_q || step_count == 8'(MAX_STEPS)) ? DONE : FETCH;
        tmo = pipe.ns_state != end_q;
      end
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= '0;
      end_q <= '0;
      lfsr <= SEED;
      pipe.sa_state <= '0;
      pipe.sa_action <= '0;
      pipe.sa_explore <= 1'b0;
      step_count <= '0;
      episode_count <= '0;
      done_timeout <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        cur_state <= start_state;
        end_q <= end_state;
        step_count <= '0;
      end
      // one Galois step per episode step, so stalls never disturb the sequence
      if (state == FETCH) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (state == SELECT) begin
        pipe.sa_state <= cur_state;
        pipe.sa_action <= explore ? ACTION_WIDTH'(lfsr[9:8]) : greedy_action;
        pipe.sa_explore <= explore;
      end
      if (state == ISSUE && pipe.sa_ready) step_count <= step_count + 8'd1;
      if (state == WAIT_NS && next == FETCH) cur_state <= pipe.ns_state;
      if (next == DONE) done_timeout <= tmo;
      if (state == DONE) episode_count <= episode_count + 16'd1;
    end
  end
endmodule

// File: doc/qlearn_episode_ctrl.md
# qlearn_episode_ctrl

Episode controller upstream of the Q-update pipeline. Walks one episode from a start state to a terminal state and picks an action each step by epsilon-greedy selection, using a 16-bit LFSR and a greedy-action lookup port. Issues one (state, action) pair per step to the pipeline over a valid/ready handshake. Waits for the pipeline's next-state result before issuing the next step.

## Interface
Parameters:
- STATE_WIDTH, 6, state index width (64 states)
- ACTION_WIDTH, 2, action index width (4 actions)
- LFSR_SEED, 16'hACE1, LFSR reset value; a seed of 0 is replaced by 16'h0001
- MAX_STEPS, 255, step limit per episode (1..255)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin an episode; sampled only in IDLE
- start_state  in  STATE_WIDTH  initial state, sampled with start
- end_state  in  STATE_WIDTH  terminal state, sampled with start
- epsilon  in  8  exploration threshold, out of 256
- greedy_addr  out  STATE_WIDTH  address driven to the greedy-action table (1-cycle synchronous read)
- greedy_action  in  ACTION_WIDTH  table read data, valid one cycle after greedy_addr
- sa_valid  out  1  (state, action) pair valid
- sa_ready  in  1  pipeline accepts the pair
- sa_state  out  STATE_WIDTH  current state
- sa_action  out  ACTION_WIDTH  chosen action
- sa_explore  out  1  1 = random action, 0 = greedy action
- ns_valid  in  1  next-state result valid
- ns_state  in  STATE_WIDTH  next state from the pipeline
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at episode end
- done_timeout  out  1  registered with done: 1 = episode ended on the step limit
- step_count  out  8  accepted pairs in the current episode
- episode_count  out  16  completed episodes; wraps at 16'hFFFF to 0

## Operation
- States: IDLE, FETCH, SELECT, ISSUE, WAIT_NS, DONE.
- IDLE
  - On start=1: latch start_state into cur_state and latch end_state. Clear step_count.
  - If start_state==end_state, go to DONE (done_timeout=0). Otherwise go to FETCH.
- FETCH
  - greedy_addr=cur_state.
  - LFSR advances one step. Galois form, right shift, taps mask 16'hB400.
  - Go to SELECT.
- SELECT
  - explore = (lfsr[7:0] < epsilon).
  - action = explore ? lfsr[9:8] : greedy_action.
  - Register action, state and explore onto sa_*. Go to ISSUE.
- ISSUE
  - sa_valid=1. sa_* hold stable until sa_valid&&sa_ready.
  - On transfer: step_count+1, go to WAIT_NS.
- WAIT_NS
  - On ns_valid:
    - If ns_state==end_state, go to DONE with done_timeout=0.
    - Else if step_count==MAX_STEPS, go to DONE with done_timeout=1.
    - Else cur_state=ns_state and go to FETCH.
  - If the end-state and step-limit conditions hold together, the end state wins (done_timeout=0).
- DONE
  - done=1 for one cycle. episode_count+1. Go to IDLE.
- Input handling:
  - start is ignored while busy.
  - ns_valid is ignored outside WAIT_NS.
  - sa_ready is ignored when sa_valid=0.
- Arithmetic:
  - The epsilon comparison is unsigned 8-bit.
  - epsilon=0 means always greedy.
  - epsilon=255 means explore unless lfsr[7:0]==255.
- Reset values (asynchronous):
  - State is IDLE and lfsr=LFSR_SEED (or 1 when the seed is 0).
  - All outputs are 0: sa_valid, sa_state, sa_action, sa_explore, greedy_addr, busy, done, done_timeout, step_count, episode_count.
- Reset during an episode aborts it at once. No done pulse is produced and episode_count is cleared.

## Timing
- start accepted at edge N: FETCH in cycle N+1, SELECT in N+2, sa_valid=1 from N+3.
- Per step with sa_ready held at 1 and ns_valid arriving k cycles after the transfer: 3+k cycles from step issue to the next FETCH.
- sa_valid rises on the edge entering ISSUE and falls on the edge after the transfer. No combinational path from sa_ready to sa_valid.
- done asserts the cycle after the final ns_valid and falls one cycle later. busy falls together with done.
- A new start is accepted the cycle after done is seen in IDLE. The shortest gap between episodes is one cycle.
- The LFSR advances exactly once per step, never while stalled, so the action sequence is deterministic for a given seed.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-ISSUE, then release.
  - Required: all outputs 0, busy=0, sa_valid=0. Then start_state=5, end_state=5 gives done at N+1, step_count=0, done_timeout=0, episode_count=1.
- Greedy episode:
  - Stimulus: epsilon=0, greedy_action fixed at 2, start 0 to end 3, ns_state returns 1, 2, 3.
  - Required: three transfers with sa_state 0, 1, 2 and sa_action 2. sa_explore=0 every step. step_count=3, done_timeout=0.
- Explore:
  - Stimulus: epsilon=255, seed 16'hACE1.
  - Required: sa_action equals lfsr[9:8] of a reference Galois model at each step, and sa_explore=1.
- Backpressure:
  - Stimulus: hold sa_ready=0 for 5 cycles in ISSUE.
  - Required: sa_* stable, LFSR unchanged, step_count unchanged. Transfer happens on the first cycle with sa_ready=1.
- Step limit:
  - Stimulus: MAX_STEPS=4, ns_state never equals end_state.
  - Required: done after the 4th ns_valid, done_timeout=1, step_count=4. If ns_state==end_state on the 4th step, done_timeout=0 instead.
- Ignored inputs:
  - Stimulus: pulse start and ns_valid while in ISSUE.
  - Required: no state change, and no extra step_count increment.
